// File: rtl/ber_pkg.sv
// Shared definitions for the BER sweep sequencer: sweep FSM states, number of
// link configurations, index -> backplane configuration mapping and the
// phase-timer width helper.
package ber_pkg;

  localparam int unsigned NUM_CFG = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_DUT,
    ST_SETTLE,
    ST_MEASURE,
    ST_STORE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic       half_period;
    logic [1:0] delay_select;
  } link_cfg_t;

  function automatic link_cfg_t cfg_of(input logic [IDX_W-1:0] idx);
    link_cfg_t c;
    c.delay_select = idx[1:0];
    c.half_period  = idx[2];
    return c;
  endfunction

  // Timer holds (cycles - 1) of the longest phase.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/error_window_counter.sv
// Saturating error counter for one measurement window.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   clr_i   - synchronous clear (priority over enable)
//   en_i    - count one error this cycle
//   count_o - current count, saturates at all-ones
module error_window_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ber_sweep_sequencer.sv
// Automatic bit-error sweep over the eight backplane link configurations.
// For each configuration: hold the backplane in reset, let it settle, count
// error pulses over a dwell window, then store the count, pass bit and best
// configuration.
// Ports:
//   clk              - test clock
//   reset            - asynchronous active-low reset
//   start            - start / restart a sweep (IDLE or DONE)
//   abort            - return to IDLE, keeps already-stored results
//   error_pulse      - one bit error per high cycle
//   cfg_delay_select - delay select to the backplane
//   cfg_half_period  - half-period select to the backplane
//   dut_reset        - active-high reset to the backplane
//   busy / done      - sweep status
//   pass_map         - bit i set when configuration i saw zero errors
//   best_index       - configuration with the lowest count (ties: lower index)
//   rd_index         - result read address
//   rd_error_count   - stored count for rd_index (combinational)
module ber_sweep_sequencer
  import ber_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned DWELL_CYCLES  = 1048576,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 error_pulse,
  output logic [1:0]           cfg_delay_select,
  output logic                 cfg_half_period,
  output logic                 dut_reset,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CFG-1:0]   pass_map,
  output logic [IDX_W-1:0]     best_index,
  input  logic [IDX_W-1:0]     rd_index,
  output logic [CNT_WIDTH-1:0] rd_error_count
);

  localparam int unsigned TW = timer_width(RESET_CYCLES, SETTLE_CYCLES, DWELL_CYCLES);
  localparam logic [TW-1:0] RESET_LOAD  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LOAD  = TW'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CFG - 1);

  state_e               state_q;
  logic [TW-1:0]        timer_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 dut_reset_q;
  logic                 busy_q;
  logic                 done_q;
  logic [NUM_CFG-1:0]   pass_q;
  logic [IDX_W-1:0]     best_idx_q;
  logic [CNT_WIDTH-1:0] best_cnt_q;
  logic [CNT_WIDTH-1:0] slot_q [NUM_CFG];

  logic [CNT_WIDTH-1:0] win_count;
  logic                 win_clr;
  logic                 win_en;
  link_cfg_t            cur_cfg;

  // Counter only runs in MEASURE; it is cleared in every other state, so the
  // STORE edge reads the final value and clears it in the same cycle.
  assign win_clr = abort || (state_q != ST_MEASURE);
  assign win_en  = (state_q == ST_MEASURE) && error_pulse;

  error_window_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_win_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (win_clr),
    .en_i    (win_en),
    .count_o (win_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      dut_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '1;
      for (int unsigned i = 0; i < NUM_CFG; i++) slot_q[i] <= '0;
    end else if (abort) begin
      state_q     <= ST_IDLE;
      dut_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_RESET_DUT;
            timer_q     <= RESET_LOAD;
            idx_q       <= '0;
            dut_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= '0;
            best_idx_q  <= '0;
            best_cnt_q  <= '1;
            for (int unsigned i = 0; i < NUM_CFG; i++) slot_q[i] <= '0;
          end
        end
        ST_RESET_DUT: begin
          if (timer_q == '0) begin
            state_q     <= ST_SETTLE;
            timer_q     <= SETTLE_LOAD;
            dut_reset_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_SETTLE: begin
          if (timer_q == '0) begin
            state_q <= ST_MEASURE;
            timer_q <= DWELL_LOAD;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_MEASURE: begin
          if (timer_q == '0) begin
            state_q <= ST_STORE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        ST_STORE: begin
          slot_q[idx_q] <= win_count;
          pass_q[idx_q] <= (win_count == '0);
          if (win_count < best_cnt_q) begin
            best_cnt_q <= win_count;
            best_idx_q <= idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q     <= ST_RESET_DUT;
            timer_q     <= RESET_LOAD;
            idx_q       <= idx_q + IDX_W'(1);
            dut_reset_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cur_cfg          = cfg_of(idx_q);
  assign cfg_delay_select = cur_cfg.delay_select;
  assign cfg_half_period  = cur_cfg.half_period;
  assign dut_reset        = dut_reset_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass_map         = pass_q;
  assign best_index       = best_idx_q;
  assign rd_error_count   = slot_q[rd_index];

endmodule

// File: tb/tb_ber_sweep_sequencer.sv
module tb_ber_sweep_sequencer;

  localparam int unsigned R  = 2;
  localparam int unsigned S  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned W  = 4;
  localparam int unsigned P  = R + S + D + 1;
  localparam int unsigned MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic         error_pulse;
  logic [1:0]   cfg_delay_select;
  logic         cfg_half_period;
  logic         dut_reset;
  logic         busy;
  logic         done;
  logic [7:0]   pass_map;
  logic [2:0]   best_index;
  logic [2:0]   rd_index;
  logic [W-1:0] rd_error_count;

  ber_sweep_sequencer #(
    .RESET_CYCLES  (R),
    .SETTLE_CYCLES (S),
    .DWELL_CYCLES  (D),
    .CNT_WIDTH     (W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .error_pulse      (error_pulse),
    .cfg_delay_select (cfg_delay_select),
    .cfg_half_period  (cfg_half_period),
    .dut_reset        (dut_reset),
    .busy             (busy),
    .done             (done),
    .pass_map         (pass_map),
    .best_index       (best_index),
    .rd_index         (rd_index),
    .rd_error_count   (rd_error_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  mode;   // 0 clean, 1 selective, 2 ignored windows, 3 saturate
    logic [7:0]  pass;
    logic [2:0]  best;
    logic [31:0] slots;  // slot i in bits [4*i +: 4]
  } vec_t;

  typedef struct {
    int unsigned idx;
    int unsigned cnt;
  } exp_t;

  vec_t vecs [4];
  exp_t sbq [$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic err_bit(input int unsigned mode, input int unsigned cfg,
                                   input int unsigned off);
    logic in_meas;
    int unsigned m;
    in_meas = (off >= R + S) && (off < R + S + D);
    m = off - (R + S);
    case (mode)
      1: return in_meas && (((cfg == 0) && (m == 0 || m == D - 1)) ||
                            ((cfg == 3) && (m >= 3) && (m <= 7)));
      2: return !in_meas;
      3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Pulse start, then run ncyc cycles checking per-cycle outputs; the bench
  // model counts pulses it drives inside MEASURE and pushes each finished
  // configuration's expected count to the scoreboard.
  task automatic sweep(input int unsigned mode, input int unsigned ncyc);
    int unsigned model;
    int unsigned ci;
    int unsigned off;
    start = 1'b1;
    tick();
    start = 1'b0;
    model = 0;
    for (int unsigned c = 0; c < ncyc; c++) begin
      ci  = c / P;
      off = c % P;
      chk("busy", {31'd0, busy}, 32'd1);
      chk("dut_reset", {31'd0, dut_reset}, {31'd0, off < R});
      chk("cfg", {29'd0, cfg_half_period, cfg_delay_select}, ci);
      chk("done_low", {31'd0, done}, 32'd0);
      error_pulse = err_bit(mode, ci, off);
      if (off >= R + S && off < R + S + D && error_pulse && model < MAXC) model++;
      if (off == P - 1) begin
        sbq.push_back('{idx: ci, cnt: model});
        model = 0;
      end
      tick();
    end
    error_pulse = 1'b0;
  endtask

  task automatic check_results(input vec_t v);
    exp_t e;
    logic [31:0] sl;
    sl = v.slots;
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("dut_reset_done", {31'd0, dut_reset}, 32'd0);
    chk("pass_map", {24'd0, pass_map}, {24'd0, v.pass});
    chk("best_index", {29'd0, best_index}, {29'd0, v.best});
    chk("sb_depth", sbq.size(), 32'd8);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rd_index = e.idx[2:0];
      #1;
      chk("slot_model", {28'd0, rd_error_count}, e.cnt);
      chk("slot_table", {28'd0, rd_error_count}, {28'd0, sl[4*e.idx +: 4]});
    end
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{mode: 2'd0, pass: 8'hFF, best: 3'd0, slots: 32'h0000_0000};
    vecs[1] = '{mode: 2'd1, pass: 8'hF6, best: 3'd1, slots: 32'h0000_5002};
    vecs[2] = '{mode: 2'd2, pass: 8'hFF, best: 3'd0, slots: 32'h0000_0000};
    vecs[3] = '{mode: 2'd3, pass: 8'h00, best: 3'd0, slots: 32'hFFFF_FFFF};

    reset = 1'b0; start = 1'b0; abort = 1'b0; error_pulse = 1'b0; rd_index = '0;
    repeat (3) tick();
    chk("rst_cfg", {29'd0, cfg_half_period, cfg_delay_select}, 32'd0);
    chk("rst_dut_reset", {31'd0, dut_reset}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {24'd0, pass_map}, 32'd0);
    chk("rst_best", {29'd0, best_index}, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    for (int unsigned v = 0; v < 4; v++) begin
      sweep(vecs[v].mode, 8 * P);
      check_results(vecs[v]);
    end

    // Abort at measure cycle 5 of config 2.
    sweep(1, 2 * P + R + S + 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_dut_reset", {31'd0, dut_reset}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_pass", {24'd0, pass_map}, 32'h02);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rd_index = e.idx[2:0];
      #1;
      chk("abort_slot", {28'd0, rd_error_count}, e.cnt);
    end
    rd_index = 3'd2;
    #1;
    chk("abort_slot2", {28'd0, rd_error_count}, 32'd0);
    repeat (3) tick();
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);
    // abort wins over a simultaneous start
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_over_start", {31'd0, busy}, 32'd0);
    sweep(0, 8 * P);
    check_results(vecs[0]);

    // Async reset during SETTLE of config 4, after config 0 stored a nonzero count.
    sweep(1, 4 * P + R + 3);
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_dut_reset", {31'd0, dut_reset}, 32'd0);
    chk("arst_cfg", {29'd0, cfg_half_period, cfg_delay_select}, 32'd0);
    chk("arst_pass", {24'd0, pass_map}, 32'd0);
    chk("arst_best", {29'd0, best_index}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    sbq.delete();
    for (int unsigned i = 0; i < 8; i++) begin
      rd_index = i[2:0];
      #1;
      chk("arst_slot", {28'd0, rd_error_count}, 32'd0);
    end
    reset = 1'b1;
    tick();
    sweep(1, 8 * P);
    check_results(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ber_sweep_sequencer.md
# ber_sweep_sequencer

Automatic sweep controller for the bit-error test backplane. On `start` it steps through all eight link configurations (2-bit delay select × half-period flag). For each one it resets the backplane, waits a settle interval, then counts error pulses over a fixed dwell window. It stores one saturating error count per configuration, plus a pass map and the best configuration, so the toplevel can drive the backplane's `delay_select`/`half_period` from this block instead of from switches.

## Interface

Parameters:
- `RESET_CYCLES`, default 4: cycles `dut_reset` is held per configuration (≥1).
- `SETTLE_CYCLES`, default 1024: cycles after backplane reset during which errors are ignored (≥1).
- `DWELL_CYCLES`, default 1048576: measurement window length per configuration (≥1).
- `CNT_WIDTH`, default 16: width of each error counter.

Ports:
- `clk`  input  1  single clock, the global test clock.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  synchronous start request, level-sampled.
- `abort`  input  1  synchronous abort, highest priority after reset.
- `error_pulse`  input  1  one bit error per high cycle, from the backplane error output.
- `cfg_delay_select`  output  2  delay select driven to the backplane.
- `cfg_half_period`  output  1  half-period select driven to the backplane.
- `dut_reset`  output  1  active-high synchronous reset to the backplane.
- `busy`  output  1  high in RESET_DUT, SETTLE, MEASURE and STORE.
- `done`  output  1  high in DONE.
- `pass_map`  output  8  bit i = 1 when configuration i counted zero errors.
- `best_index`  output  3  configuration with the lowest count.
- `rd_index`  input  3  result read address.
- `rd_error_count`  output  CNT_WIDTH  stored count for `rd_index`, combinational read.

## Operation

- **Configuration mapping.** Index i maps to `cfg_delay_select = i[1:0]` and `cfg_half_period = i[2]`. Indices are swept 0→7.
- **IDLE.** `start` → RESET_DUT. Entering RESET_DUT clears all 8 counts, `pass_map` and `best_index`, and sets index = 0.
- **RESET_DUT.** `dut_reset` = 1 for `RESET_CYCLES` cycles, with cfg outputs already showing the current index. Then → SETTLE.
- **SETTLE.** Lasts `SETTLE_CYCLES`; `error_pulse` is ignored. Then → MEASURE.
- **MEASURE.** Lasts `DWELL_CYCLES`. Each cycle with `error_pulse` = 1 increments the window counter. The counter saturates at 2^CNT_WIDTH−1 and never wraps. Then → STORE.
- **STORE.** One cycle:
  - Write the count to slot[index].
  - Set `pass_map[index]` = (count == 0).
  - If count < best_count (strict), update `best_index`/best_count, so ties keep the lower index. best_count starts at all-ones.
  - If index == 7 → DONE; otherwise increment index and go → RESET_DUT.
- **DONE.** Results held. `start` → RESET_DUT (full restart, results cleared).
- **abort** (any state except IDLE) → IDLE on the next edge:
  - `dut_reset` = 0, window counter cleared.
  - Slots already stored are kept; `done` = 0.
  - `abort` and `start` in the same cycle: abort wins.
- **Async reset:** all state → IDLE immediately, mid-operation included.

## Timing

- **Reset values:** `cfg_delay_select` = 0, `cfg_half_period` = 0, `dut_reset` = 0, `busy` = 0, `done` = 0, `pass_map` = 0, `best_index` = 0, all slots 0.
- **Registered outputs.** All outputs are registered except `rd_error_count`, which has zero latency from `rd_index`.
- **Start.** `start` high at edge k in IDLE/DONE gives `busy` = 1 and `dut_reset` = 1 from k+1.
- **Per-configuration time:** P = RESET_CYCLES + SETTLE_CYCLES + DWELL_CYCLES + 1 cycles.
  - `done` rises 8·P cycles after the start edge.
  - cfg outputs change only on the STORE→RESET_DUT edge, so they are stable for the whole reset/settle/measure window.
- **Error window.** An `error_pulse` sampled on the first MEASURE edge counts; one sampled on the STORE edge does not.
- **Pass/best updates.** `pass_map` and `best_index` update on the STORE→next edge.

## Structure

- **Shared package `ber_pkg`:**
  - state encoding (IDLE, RESET_DUT, SETTLE, MEASURE, STORE, DONE);
  - `NUM_CFG` = 8;
  - the index→(delay_select, half_period) mapping;
  - the phase-timer width derived from the max of the three cycle parameters.
- **One sub-module, `error_window_counter`:** saturating CNT_WIDTH counter with clear and enable inputs, instantiated once.
- **Other logic:** the phase timer, result register file and best tracker stay in the top module.

## Test plan

All scenarios use RESET_CYCLES=2, SETTLE_CYCLES=8, DWELL_CYCLES=16, CNT_WIDTH=4, so P = 27.

- **Clean sweep.** `error_pulse` = 0 and `start` pulsed → `done` at start+216. `pass_map` = 8'hFF, `best_index` = 0, cfg sequence 0..7 each held 27 cycles.
- **Selective errors.** 2 pulses in MEASURE of config 0 and 5 in config 3 → slot0 = 2, slot3 = 5, `pass_map` = 8'hF6, `best_index` = 1.
- **Ignored windows.** `error_pulse` high throughout every RESET_DUT, SETTLE and STORE cycle but never in MEASURE → `pass_map` = 8'hFF, all slots 0.
- **Saturation.** `error_pulse` held at 1 → every slot = 15, `pass_map` = 0, `best_index` = 0.
- **Abort mid-sweep.** `abort` in cycle 5 of MEASURE for config 2 → next cycle IDLE, `busy` = 0, `dut_reset` = 0. Slots 0–1 are retained; a new `start` restarts at config 0 with everything cleared.
- **Async reset.** `reset` = 0 during SETTLE of config 4 → all outputs return to reset values immediately. A restart after release completes normally.
